// File: rtl/clkdiv_multi.sv
// ============================================================================
//  Module      : clkdiv_multi
//  Description : Multi-channel runtime-programmable clock divider. Each of NCH
//                channels produces a divided square wave or single-cycle pulse
//                train plus a wrap tick. Divisor/mode writes go through a
//                per-channel shadow register and are applied glitch-free at
//                the next wrap (or at once when the channel is idle).
//  Options     : CLKDIV_SYNC_EN - adds a 'sync' input that restarts all
//                channels at count 0 and applies pending shadows.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_multi #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int NCH      = 4,
  parameter int CW       = 32,
  parameter int DEF_FREQ = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NCH-1:0]                      en,
  input  logic                                wr_en,
  input  logic [((NCH>1)?$clog2(NCH):1)-1:0]  wr_ch,
  input  logic [CW-1:0]                       wr_half,
  input  logic                                wr_mode,
`ifdef CLKDIV_SYNC_EN
  input  logic                                sync,
`endif
  output logic [NCH-1:0]                      clk_out,
  output logic [NCH-1:0]                      tick,
  output logic [NCH-1:0]                      pending
);

  localparam int            WCH        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] c_DEF_HALF = CW'(CLK_FREQ / (2 * DEF_FREQ));
  localparam logic [CW-1:0] c_ONE      = CW'(1);
  localparam logic [CW-1:0] c_ZERO     = '0;

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      // Channel index as a wr_ch-width constant; indices >= NCH never match.
      localparam logic [WCH-1:0] c_IDX = WCH'(i);

      logic [CW-1:0] r_cnt;
      logic [CW-1:0] r_half;
      logic          r_mode;
      logic [CW-1:0] r_sh_half;
      logic          r_sh_mode;
      logic          r_pend;
      logic          r_out;
      logic          r_tick;

      logic          w_wr_hit;
      logic          w_idle;
      logic          w_wrap;
      logic [CW-1:0] w_next_half;
      logic          w_next_mode;

      assign w_wr_hit    = wr_en && (wr_ch == c_IDX);
      assign w_idle      = !en[i] || (r_half == c_ZERO);
      assign w_wrap      = !w_idle && (r_cnt == (r_half - c_ONE));
      // Divisor/mode in force after this edge's wrap (shadow wins if pending).
      assign w_next_half = r_pend ? r_sh_half : r_half;
      assign w_next_mode = r_pend ? r_sh_mode : r_mode;

      // Per-channel counter, output shaping and shadow/apply handling.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt     <= c_ZERO;
          r_half    <= c_DEF_HALF;
          r_mode    <= 1'b0;
          r_sh_half <= c_DEF_HALF;
          r_sh_mode <= 1'b0;
          r_pend    <= 1'b0;
          r_out     <= 1'b0;
          r_tick    <= 1'b0;
        end else begin
          r_tick <= 1'b0;
`ifdef CLKDIV_SYNC_EN
          if (sync) begin
            // Phase-align: restart from zero and take any pending shadow.
            r_cnt <= c_ZERO;
            r_out <= 1'b0;
            if (r_pend) begin
              r_half <= r_sh_half;
              r_mode <= r_sh_mode;
              r_pend <= 1'b0;
            end
          end else
`endif
          if (w_idle) begin
            // Idle channel: apply at once and restart the period cleanly,
            // otherwise hold (disabled) or park at zero (half==0).
            if (r_pend) begin
              r_half <= r_sh_half;
              r_mode <= r_sh_mode;
              r_pend <= 1'b0;
              r_cnt  <= c_ZERO;
              r_out  <= 1'b0;
            end else if (r_half == c_ZERO) begin
              r_cnt <= c_ZERO;
              r_out <= 1'b0;
            end
          end else if (w_wrap) begin
            r_cnt  <= c_ZERO;
            r_tick <= 1'b1;
            if (r_pend) begin
              r_half <= r_sh_half;
              r_mode <= r_sh_mode;
              r_pend <= 1'b0;
            end
            // Output takes the value of the mode in force from this wrap on.
            if (w_next_half == c_ZERO) begin
              r_out <= 1'b0;
            end else if (w_next_mode) begin
              r_out <= 1'b1;
            end else begin
              r_out <= ~r_out;
            end
          end else begin
            r_cnt <= r_cnt + c_ONE;
            if (r_mode) begin
              r_out <= 1'b0;
            end
          end

          // A write lands after any apply above, so it stays pending.
          if (w_wr_hit) begin
            r_sh_half <= wr_half;
            r_sh_mode <= wr_mode;
            r_pend    <= 1'b1;
          end
        end
      end

      assign clk_out[i] = r_out;
      assign tick[i]    = r_tick;
      assign pending[i] = r_pend;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_multi.sv
// ============================================================================
//  Module      : tb_clkdiv_multi
//  Description : Self-checking bench for clkdiv_multi. Directed scenarios plus
//                randomized writes/enables compared against a cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clkdiv_multi;

  localparam int CLK_FREQ = 40;
  localparam int DEF_FREQ = 1;
  localparam int NCH      = 5;
  localparam int CW       = 16;
  localparam int WCH      = 3;
  localparam int DEF_HALF = CLK_FREQ / (2 * DEF_FREQ);

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [WCH-1:0] wr_ch;
  logic [CW-1:0]  wr_half;
  logic           wr_mode;
  logic           sync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clkdiv_multi #(
    .CLK_FREQ (CLK_FREQ),
    .NCH      (NCH),
    .CW       (CW),
    .DEF_FREQ (DEF_FREQ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_half (wr_half),
    .wr_mode (wr_mode),
`ifdef CLKDIV_SYNC_EN
    .sync    (sync),
`endif
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  // Reference model: position within the current period, active and shadow
  // settings, and the expected output levels after each edge.
  int m_pos   [NCH];
  int m_half  [NCH];
  int m_mode  [NCH];
  int m_shh   [NCH];
  int m_shm   [NCH];
  int m_pend  [NCH];
  int m_out   [NCH];
  int m_tick  [NCH];

  task automatic model_apply(int c);
    m_half[c] = m_shh[c];
    m_mode[c] = m_shm[c];
    m_pend[c] = 0;
  endtask

  task automatic model_step();
    bit do_sync;
`ifdef CLKDIV_SYNC_EN
    do_sync = sync;
`else
    do_sync = 1'b0;
`endif
    for (int c = 0; c < NCH; c++) begin
      if (!rst) begin
        m_pos[c] = 0; m_half[c] = DEF_HALF; m_mode[c] = 0;
        m_shh[c] = DEF_HALF; m_shm[c] = 0; m_pend[c] = 0;
        m_out[c] = 0; m_tick[c] = 0;
      end else begin
        m_tick[c] = 0;
        if (do_sync) begin
          m_pos[c] = 0; m_out[c] = 0;
          if (m_pend[c] != 0) model_apply(c);
        end else if (!en[c] || m_half[c] == 0) begin
          if (m_pend[c] != 0) begin
            model_apply(c);
            m_pos[c] = 0; m_out[c] = 0;
          end else if (m_half[c] == 0) begin
            m_pos[c] = 0; m_out[c] = 0;
          end
        end else if (m_pos[c] + 1 == m_half[c]) begin
          // End of a half-period: tick, adopt pending settings, shape output.
          m_tick[c] = 1;
          m_pos[c]  = 0;
          if (m_pend[c] != 0) model_apply(c);
          if (m_half[c] == 0)      m_out[c] = 0;
          else if (m_mode[c] != 0) m_out[c] = 1;
          else                     m_out[c] = 1 - m_out[c];
        end else begin
          m_pos[c] = m_pos[c] + 1;
          if (m_mode[c] != 0) m_out[c] = 0;
        end
        if (wr_en && int'(wr_ch) == c) begin
          m_shh[c]  = int'(wr_half);
          m_shm[c]  = int'(wr_mode);
          m_pend[c] = 1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [NCH-1:0] eo, et, ep;
    for (int c = 0; c < NCH; c++) begin
      eo[c] = (m_out[c]  != 0);
      et[c] = (m_tick[c] != 0);
      ep[c] = (m_pend[c] != 0);
    end
    checks++;
    assert (clk_out === eo) else begin
      errors++;
      $error("FAIL %s clk_out: observed=%b expected=%b", tag, clk_out, eo);
    end
    checks++;
    assert (tick === et) else begin
      errors++;
      $error("FAIL %s tick: observed=%b expected=%b", tag, tick, et);
    end
    checks++;
    assert (pending === ep) else begin
      errors++;
      $error("FAIL %s pending: observed=%b expected=%b", tag, pending, ep);
    end
  endtask

  // One clock: model and DUT advance on the same edge, compare 1 time unit later.
  task automatic step(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic write(int ch, int half, int mode, string tag);
    wr_en   = 1'b1;
    wr_ch   = WCH'(ch);
    wr_half = CW'(half);
    wr_mode = mode[0];
    step(tag);
    wr_en   = 1'b0;
  endtask

  initial begin : stim
    int rise, nticks, n, t1, t2, ones, bad;
    logic [19:0] s;

    rst = 1'b0; en = '1; wr_en = 1'b0; wr_ch = '0;
    wr_half = '0; wr_mode = 1'b0; sync = 1'b0;

    // Reset state
    step("reset");
    step("reset");
    chk("reset_clk_out", 32'(clk_out), 0);
    chk("reset_pending", 32'(pending), 0);
    rst = 1'b1;

    // Default divisor: first rise at DEF_HALF, one tick per half-period
    rise = -1; nticks = 0;
    for (int t = 1; t <= 3 * DEF_HALF; t++) begin
      step("default");
      if (rise < 0 && clk_out[0]) rise = t;
      if (tick[0]) nticks++;
    end
    chk("default_first_rise", 32'(rise), 32'(DEF_HALF));
    chk("default_tick_count", 32'(nticks), 3);

    // Mid-period write to ch1: pending until old wrap, then period 10, 5/5
    for (int t = 0; t < 7; t++) step("ch1_pre");
    write(1, 5, 0, "ch1_write");
    chk("ch1_pending_set", 32'(pending[1]), 1);
    n = 0;
    while (pending[1] && n < 3 * DEF_HALF) begin step("ch1_wait"); n++; end
    chk("ch1_pending_cleared", 32'(pending[1]), 0);
    for (int k = 0; k < 20; k++) begin step("ch1_run"); s[k] = clk_out[1]; end
    bad = 0; ones = 0;
    for (int k = 0; k < 20; k++) ones += int'(s[k]);
    for (int k = 0; k < 15; k++) if (s[k] == s[k+5]) bad++;
    chk("ch1_duty_ones", 32'(ones), 10);
    chk("ch1_half_period", 32'(bad), 0);

    // Disabled ch2: write applies on the next edge; pulse every 4th cycle
    en[2] = 1'b0;
    step("ch2_off");
    write(2, 4, 1, "ch2_write");
    step("ch2_apply");
    chk("ch2_pending_cleared", 32'(pending[2]), 0);
    en[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin step("ch2_run"); s[k] = clk_out[2]; end
    ones = 0; bad = 0;
    for (int k = 0; k < 12; k++) ones += int'(s[k]);
    for (int k = 0; k < 8; k++) if (s[k] != s[k+4]) bad++;
    chk("ch2_pulse_count", 32'(ones), 3);
    chk("ch2_pulse_period", 32'(bad), 0);
    chk("ch2_pulse_last", 32'(s[11]), 1);

    // Write in the wrap cycle of ch0 with 6 already pending
    write(0, 6, 0, "ch0_write6");
    n = 0;
    while (m_pos[0] + 1 != m_half[0] && n < 3 * DEF_HALF) begin step("ch0_seek"); n++; end
    write(0, 3, 0, "ch0_write3_at_wrap");
    chk("ch0_wrap_tick", 32'(tick[0]), 1);
    chk("ch0_still_pending", 32'(pending[0]), 1);
    t1 = -1; t2 = -1;
    for (int t = 1; t <= 12; t++) begin
      step("ch0_run");
      if (tick[0]) begin
        if (t1 < 0) t1 = t;
        else if (t2 < 0) t2 = t;
      end
    end
    chk("ch0_first_interval", 32'(t1), 6);
    chk("ch0_second_interval", 32'(t2 - t1), 3);

    // half=0 on running ch3 stops it after its wrap
    write(3, 0, 0, "ch3_write0");
    n = 0;
    while (pending[3] && n < 3 * DEF_HALF) begin step("ch3_wait"); n++; end
    chk("ch3_pending_cleared", 32'(pending[3]), 0);
    step("ch3_stop");
    for (int t = 0; t < 5; t++) begin
      step("ch3_stopped");
      chk("ch3_out_low", 32'({clk_out[3], tick[3]}), 0);
    end
    // Out-of-range channel index is ignored
    write(5, 2, 1, "bad_ch_write");
    write(7, 2, 1, "bad_ch_write");
    step("bad_ch_after");
    // Reset mid-period clears everything on the next edge
    for (int t = 0; t < 3; t++) step("pre_rst");
    rst = 1'b0;
    step("mid_reset");
    chk("mid_reset_outputs", 32'({clk_out, tick, pending}), 0);
    rst = 1'b1;

`ifdef CLKDIV_SYNC_EN
    // Sync phase-aligns ch0 (half 3) and ch1 (half 7)
    write(0, 3, 0, "sync_w0");
    write(1, 7, 0, "sync_w1");
    n = 0;
    while ((pending[0] || pending[1]) && n < 3 * DEF_HALF) begin step("sync_wait"); n++; end
    chk("sync_pre_applied", 32'(pending[1:0]), 0);
    step("sync_pre");
    sync = 1'b1;
    step("sync_pulse");
    sync = 1'b0;
    chk("sync_outputs_low", 32'({clk_out[1:0], tick[1:0]}), 0);
    t1 = -1; t2 = -1;
    for (int t = 1; t <= 10; t++) begin
      step("sync_run");
      if (tick[0] && t1 < 0) t1 = t;
      if (tick[1] && t2 < 0) t2 = t;
    end
    chk("sync_ch0_first_tick", 32'(t1), 3);
    chk("sync_ch1_first_tick", 32'(t2), 7);
`endif

    // Randomized writes, enables and (when present) sync pulses
    for (int t = 0; t < 600; t++) begin
      en = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '1;
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_ch   = WCH'($urandom_range(0, 7));
      wr_half = CW'($urandom_range(0, 9));
      wr_mode = $urandom_range(0, 1) == 1;
`ifdef CLKDIV_SYNC_EN
      sync    = ($urandom_range(0, 40) == 0);
`endif
      rst     = ($urandom_range(0, 150) != 0);
      step("random");
    end
    wr_en = 1'b0; sync = 1'b0; rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
